ddr_user_port_arbiter: RTL
==========================

Name: ddr_user_port_arbiter

Overview:
- Two-requester round-robin arbiter for the single DDR3 controller user port. It sits between the test traffic generators or system masters and the DDR IP user interface.
- Grants the port to one requester at a time and holds the grant for a full burst: command, then all write or read data beats.
- Forwards commands, write data and read data, and blocks all traffic until the controller reports ddr_init_done.

Parameters:
AW, 28, address width per requester and on the DDR side
DW, 128, user data width (one beat)
LW, 4, burst length field width; burst = len+1 beats (1..2^LW)
TIMEOUT_CYC, 1024, stall limit in cycles (used only with the optional feature)

Ports:
core_clk  input  1  user clock of the DDR controller; all logic on rising edge
core_rst_n  input  1  asynchronous active-low reset
ddr_init_done  input  1  DDR controller calibration/init complete
req_valid  input  2  per-requester command valid
req_ready  output  2  per-requester command accept (one-cycle pulse)
req_addr  input  2*AW  packed addresses; requester i at [i*AW +: AW]
req_len  input  2*LW  packed burst lengths minus one
req_write  input  2  1 = write burst, 0 = read burst
req_wdata  input  2*DW  packed write data
req_wvalid  input  2  per-requester write data valid
req_wready  output  2  per-requester write data ready
req_rdata  output  DW  read data, broadcast to both requesters
req_rvalid  output  2  read data valid, only for the granted requester
ddr_cmd_valid  output  1  command valid to the controller
ddr_cmd_ready  input  1  controller accepts the command
ddr_cmd_addr  output  AW  latched address
ddr_cmd_len  output  LW  latched length
ddr_cmd_write  output  1  latched direction
ddr_wdata  output  DW  write data of the granted requester
ddr_wvalid  output  1  write data valid
ddr_wready  input  1  controller accepts a write beat
ddr_rdata  input  DW  read data from the controller
ddr_rvalid  input  1  read beat valid; no backpressure
grant_id  output  1  granted requester index
busy  output  1  transaction in progress
err_flag  output  1  sticky timeout error

Behaviour:
- Clocking and reset: everything is clocked on core_clk. Asynchronous reset on core_rst_n low clears all of the following:
  - all outputs go to 0;
  - state goes to IDLE;
  - last_grant is set to 1, so requester 0 wins first.
- Reset asserted mid-burst abandons the burst immediately; no further DDR handshakes occur.
- States:
  - IDLE: busy=0.
    - If ddr_init_done=1 and |req_valid, pick the winner. If exactly one requester is valid, it wins. If both are valid, the winner is ~last_grant.
    - In the same cycle, assert req_ready[winner]=1 (combinational; the command is accepted this cycle).
    - Latch addr, len and write into registers, set grant_id, and go to CMD.
    - If ddr_init_done=0, the arbiter never asserts req_ready.
  - CMD: ddr_cmd_valid=1 with the latched fields, busy=1.
    - On ddr_cmd_ready, load beat_cnt=len and go to WDATA (write) or RDATA (read).
    - Minimum latency from req acceptance to ddr_cmd_valid is 1 cycle.
  - WDATA: write data passes through combinationally.
    - ddr_wdata = req_wdata of the grant.
    - ddr_wvalid = req_wvalid[grant].
    - req_wready[grant] = ddr_wready; the other requester's wready is 0.
    - Each beat where ddr_wvalid && ddr_wready fires decrements beat_cnt.
    - The beat that fires with beat_cnt==0 is the last: go to IDLE and set last_grant=grant_id.
  - RDATA: req_rdata = ddr_rdata. req_rvalid[grant] = ddr_rvalid; the other requester's rvalid is 0.
    - Each ddr_rvalid decrements beat_cnt.
    - The beat with beat_cnt==0 is the last: go to IDLE and update last_grant.
- One outstanding transaction at a time. A new arbitration happens no earlier than the cycle after the last beat (IDLE cycle).
- ddr_init_done is sampled only in IDLE. Deassertion mid-burst does not affect the burst in progress.
- Read beats arriving in IDLE or CMD are dropped; req_rvalid stays 0.
- beat_cnt is LW bits wide with no wrap. len = 2^LW-1 gives 2^LW beats.

Optional Feature:
- Macro: DDR_ARB_TIMEOUT_EN.
- With the macro defined:
  - A stall counter runs in CMD, WDATA and RDATA.
  - The counter clears on any handshake (cmd, write beat, read beat) and on entering IDLE.
  - When the counter reaches TIMEOUT_CYC-1 without a handshake:
    - err_flag is set (sticky until reset);
    - the burst is abandoned and the state returns to IDLE;
    - last_grant is updated as for normal completion.
- Without the macro: no counter exists, err_flag is tied to 0, and a stalled burst waits forever.

Test Plan:
- Hold ddr_init_done=0 with req_valid=2'b11 for 50 cycles -> req_ready stays 0 and ddr_cmd_valid stays 0. Raise ddr_init_done -> req_ready=2'b01 in the next cycle in which it is sampled.
- Requester 0 write, addr=0x100, len=3, ddr_cmd_ready after 2 cycles, ddr_wready toggling -> ddr_cmd_addr=0x100, ddr_cmd_write=1, exactly 4 write beats forwarded in order, then busy=0.
- Both requesters valid continuously with read len=0 -> grants alternate 0,1,0,1. Each burst's single ddr_rvalid beat appears only on req_rvalid of the granted requester.
- Requester 1 read, len=15 (LW=4) -> 16 rvalid beats on req_rvalid[1], req_rvalid[0]=0 throughout, IDLE after the 16th beat.
- Assert core_rst_n=0 during the 3rd write beat of a len=7 burst -> all outputs 0 asynchronously. After release, the next grant goes to requester 0.
- With DDR_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, and ddr_cmd_ready held 0 -> err_flag rises 16 cycles after CMD entry and the state returns to IDLE. Without the macro, err_flag stays 0.

Source files
------------

// File: rtl/ddr_user_port_arbiter.sv
// Two-requester round-robin arbiter for the single DDR3 controller user port.
// Optional stall timeout is compiled in when DDR_ARB_TIMEOUT_EN is defined.
module ddr_user_port_arbiter #(
    parameter int AW          = 28,
    parameter int DW          = 128,
    parameter int LW          = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic            core_clk,
    input  logic            core_rst_n,
    input  logic            ddr_init_done,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*LW-1:0] req_len,
    input  logic [1:0]      req_write,
    input  logic [2*DW-1:0] req_wdata,
    input  logic [1:0]      req_wvalid,
    output logic [1:0]      req_wready,
    output logic [DW-1:0]   req_rdata,
    output logic [1:0]      req_rvalid,
    output logic            ddr_cmd_valid,
    input  logic            ddr_cmd_ready,
    output logic [AW-1:0]   ddr_cmd_addr,
    output logic [LW-1:0]   ddr_cmd_len,
    output logic            ddr_cmd_write,
    output logic [DW-1:0]   ddr_wdata,
    output logic            ddr_wvalid,
    input  logic            ddr_wready,
    input  logic [DW-1:0]   ddr_rdata,
    input  logic            ddr_rvalid,
    output logic            grant_id,
    output logic            busy,
    output logic            err_flag
);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t        state_q, state_d;
    logic          last_grant_q;
    logic          grant_q;
    logic          write_q;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] beat_cnt_q;

    logic winner;
    logic accept;
    logic cmd_fire;
    logic beat_fire;
    logic done;

`ifdef DDR_ARB_TIMEOUT_EN
    localparam int SW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [SW-1:0] stall_q;
    logic          err_q;
    logic          timeout;
`endif

    // On contention the requester that did not win last time takes the port.
    assign winner = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        cmd_fire      = 1'b0;
        beat_fire     = 1'b0;
        done          = 1'b0;
        req_ready     = 2'b00;
        req_wready    = 2'b00;
        req_rvalid    = 2'b00;
        req_rdata     = '0;
        ddr_cmd_valid = 1'b0;
        ddr_wdata     = '0;
        ddr_wvalid    = 1'b0;
        busy          = 1'b0;
`ifdef DDR_ARB_TIMEOUT_EN
        timeout       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // req_ready is combinational, so it is gated by reset to stay 0 while reset is held.
                if (ddr_init_done && (|req_valid) && core_rst_n) begin
                    accept            = 1'b1;
                    req_ready[winner] = 1'b1;
                    state_d           = CMD;
                end
            end
            CMD: begin
                busy          = 1'b1;
                ddr_cmd_valid = 1'b1;
                if (ddr_cmd_ready) begin
                    cmd_fire = 1'b1;
                    state_d  = write_q ? WDATA : RDATA;
                end
            end
            WDATA: begin
                busy                = 1'b1;
                ddr_wdata           = grant_q ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
                ddr_wvalid          = req_wvalid[grant_q];
                req_wready[grant_q] = ddr_wready;
                beat_fire           = req_wvalid[grant_q] && ddr_wready;
            end
            RDATA: begin
                busy                = 1'b1;
                req_rdata           = ddr_rdata;
                req_rvalid[grant_q] = ddr_rvalid;
                beat_fire           = ddr_rvalid;
            end
            default: state_d = IDLE;
        endcase

        // beat_cnt holds the beats remaining after the current one.
        if (beat_fire && (beat_cnt_q == '0)) begin
            done    = 1'b1;
            state_d = IDLE;
        end

`ifdef DDR_ARB_TIMEOUT_EN
        timeout = (state_q != IDLE) && !cmd_fire && !beat_fire &&
                  (stall_q == SW'(TIMEOUT_CYC - 1));
        if (timeout) begin
            done    = 1'b1;
            state_d = IDLE;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q <= winner;
                addr_q  <= winner ? req_addr[AW +: AW] : req_addr[0 +: AW];
                len_q   <= winner ? req_len[LW +: LW] : req_len[0 +: LW];
                write_q <= req_write[winner];
            end
            if (cmd_fire) begin
                beat_cnt_q <= len_q;
            end else if (beat_fire && (beat_cnt_q != '0)) begin
                beat_cnt_q <= beat_cnt_q - 1'b1;
            end
            if (done) begin
                last_grant_q <= grant_q;
            end
        end
    end

`ifdef DDR_ARB_TIMEOUT_EN
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if ((state_q == IDLE) || cmd_fire || beat_fire || timeout) begin
                stall_q <= '0;
            end else begin
                stall_q <= stall_q + 1'b1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_flag = err_q;
`else
    assign err_flag = 1'b0;
`endif

    assign grant_id      = grant_q;
    assign ddr_cmd_addr  = addr_q;
    assign ddr_cmd_len   = len_q;
    assign ddr_cmd_write = write_q;

endmodule
